// File: rtl/gaussian_blur_3x3.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_blur_3x3
// Brief    : Two-stage pipelined 3x3 Gaussian blur, kernel [1 2 1;2 4 2;1 2 1]/16.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian_blur_3x3 #(
    parameter int DATA_W = 8,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] lu,
    input  logic [DATA_W-1:0] cu,
    input  logic [DATA_W-1:0] ru,
    input  logic [DATA_W-1:0] lc,
    input  logic [DATA_W-1:0] cc,
    input  logic [DATA_W-1:0] rc,
    input  logic [DATA_W-1:0] lb,
    input  logic [DATA_W-1:0] cb,
    input  logic [DATA_W-1:0] rb,
    output logic [DATA_W-1:0] blurred,
    output logic              out_valid
);

    localparam int              c_RW    = DATA_W + 2;
    localparam int              c_CW    = DATA_W + 3;
    localparam int              c_SW    = DATA_W + 4;
    localparam logic [c_SW-1:0] c_RND   = (ROUND != 0) ? c_SW'(8) : '0;

    logic [c_RW-1:0]   w_row_u;
    logic [c_CW-1:0]   w_row_c;
    logic [c_RW-1:0]   w_row_b;
    logic [c_SW-1:0]   w_sum;

    logic [c_RW-1:0]   r_row_u;
    logic [c_CW-1:0]   r_row_c;
    logic [c_RW-1:0]   r_row_b;
    logic              r_v1;
    logic [DATA_W-1:0] r_blurred;
    logic              r_v2;

    // Row weights realised as bit shifts via concatenation
    assign w_row_u = {2'b00, lu} + {1'b0, cu, 1'b0} + {2'b00, ru};
    assign w_row_c = {2'b00, lc, 1'b0} + {1'b0, cc, 2'b00} + {2'b00, rc, 1'b0};
    assign w_row_b = {2'b00, lb} + {1'b0, cb, 1'b0} + {2'b00, rb};

    // Max 16*(2^DATA_W-1)+8 still fits in DATA_W+4 bits
    assign w_sum = {2'b00, r_row_u} + {1'b0, r_row_c} + {2'b00, r_row_b} + c_RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_u <= '0;
            r_row_c <= '0;
            r_row_b <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_row_u <= w_row_u;
                r_row_c <= w_row_c;
                r_row_b <= w_row_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blurred <= '0;
            r_v2      <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_blurred <= w_sum[c_SW-1:4];
            end
        end
    end

    assign blurred   = r_blurred;
    assign out_valid = r_v2;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_blur_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaussian_blur_3x3
// Brief    : Scoreboard bench driving truncating and rounding instances in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gaussian_blur_3x3;

    typedef struct packed {
        logic [7:0] e0;
        logic [7:0] e1;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] lu, cu, ru, lc, cc, rc, lb, cb, rb;
    logic [7:0] blurred0, blurred1;
    logic       out_valid0, out_valid1;

    int   errors;
    int   checks;
    exp_t sb_q[$];

    gaussian_blur_3x3 #(.DATA_W(8), .ROUND(0)) u_dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .lu(lu), .cu(cu), .ru(ru), .lc(lc), .cc(cc), .rc(rc),
        .lb(lb), .cb(cb), .rb(rb),
        .blurred(blurred0), .out_valid(out_valid0)
    );

    gaussian_blur_3x3 #(.DATA_W(8), .ROUND(1)) u_dut_round (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .lu(lu), .cu(cu), .ru(ru), .lc(lc), .cc(cc), .rc(rc),
        .lb(lb), .cb(cb), .rb(rb),
        .blurred(blurred1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int ref_blur(input int a, b, c, d, e, f, g, h, i, input int rnd);
        int s;
        s = a + 2*b + c + 2*d + 4*e + 2*f + g + 2*h + i;
        return (s + (rnd ? 8 : 0)) >> 4;
    endfunction

    task automatic send(input logic v, input logic [7:0] a, b, c, d, e, f, g, h, i,
                        input int e0, input int e1);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        lu = a; cu = b; ru = c; lc = d; cc = e; rc = f; lb = g; cb = h; rb = i;
        if (v) begin
            x.e0 = 8'(e0);
            x.e1 = 8'(e1);
            sb_q.push_back(x);
        end
    endtask

    task automatic idle();
        send(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops one expected entry for every presented result
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && (out_valid0 || out_valid1)) begin
            check("valid_match", int'(out_valid1), int'(out_valid0));
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                x = sb_q.pop_front();
                check("blur_trunc", int'(blurred0), int'(x.e0));
                check("blur_round", int'(blurred1), int'(x.e1));
            end
        end
    end

    initial begin
        int a, b, c, d, e, f, g, h, i, n, budget;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        {lu, cu, ru, lc, cc, rc, lb, cb, rb} = '0;
        #12;
        check("reset_blur0", int'(blurred0), 0);
        check("reset_blur1", int'(blurred1), 0);
        check("reset_valid", int'(out_valid0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed windows: hand-computed truncate / round results
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(1, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
        send(1, 0, 0, 0, 0, 255, 0, 0, 0, 0, 63, 64);
        idle();
        send(1, 16, 0, 16, 0, 0, 0, 16, 0, 16, 4, 4);
        send(1, 0, 10, 0, 10, 20, 10, 0, 10, 0, 10, 10);
        send(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        send(1, 0, 100, 0, 0, 0, 0, 0, 0, 0, 12, 13);
        send(1, 0, 0, 0, 0, 0, 0, 0, 100, 0, 12, 13);
        send(1, 0, 0, 0, 100, 0, 0, 0, 0, 0, 12, 13);
        send(1, 0, 0, 0, 0, 0, 100, 0, 0, 0, 12, 13);
        idle();
        idle();
        idle();

        // Back-to-back sequence followed by hold
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(1, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
        send(1, 0, 0, 0, 0, 255, 0, 0, 0, 0, 63, 64);
        idle();
        idle();
        idle();
        idle();
        check("hold_blur0", int'(blurred0), 63);
        check("hold_blur1", int'(blurred1), 64);
        check("hold_valid", int'(out_valid0), 0);

        // Asynchronous reset while results are in flight
        send(1, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200);
        send(1, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_blur0", int'(blurred0), 0);
        check("async_rst_blur1", int'(blurred1), 0);
        check("async_rst_valid", int'(out_valid0), 0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        check("post_rst_valid", int'(out_valid0), 0);

        // Random windows with random gaps against the reference model
        n = 0;
        while (n < 1000) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
            d = $urandom_range(0, 255); e = $urandom_range(0, 255); f = $urandom_range(0, 255);
            g = $urandom_range(0, 255); h = $urandom_range(0, 255); i = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                send(1, 8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i),
                     ref_blur(a, b, c, d, e, f, g, h, i, 0),
                     ref_blur(a, b, c, d, e, f, g, h, i, 1));
                n++;
            end else begin
                send(0, 8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i), 0, 0);
            end
        end
        idle();

        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
